// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner: shadow-latched hex word, per-digit decode,
// leading-zero blanking, anti-ghosting guard at each slot start and a frame-complete pulse.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_C = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            4'hF:    s = 7'h47;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dpin_q, dpin_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic [DIGITS-1:0]   blank_s;
    logic                upper_zero_s;
    logic [3:0]          nib_s;
    logic                dp_sel_s;
    logic                blank_sel_s;
    logic                lit_s;
    logic [DIGITS-1:0]   one_hot_s;
    logic [6:0]          seg_raw_s;

    // Shadow capture and slot/digit sequencing.
    always_comb begin
        if (load) begin
            val_d  = value;
            dpin_d = dp_in;
        end else begin
            val_d  = val_q;
            dpin_d = dpin_q;
        end

        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (idx_q == IDX_MAX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // A digit is blanked when it and everything above it are zero; digit 0 always shows.
    always_comb begin
        blank_s      = '0;
        upper_zero_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero_s = upper_zero_s && (val_q[4*i +: 4] == 4'h0);
            blank_s[i]   = blank_lz && upper_zero_s && (i != 0);
        end
    end

    // Select the current digit and form next-state outputs from pre-edge (cnt, idx).
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_s       = val_q[4*i +: 4];
                dp_sel_s    = dpin_q[i];
                blank_sel_s = blank_s[i];
            end else begin
                nib_s       = nib_s;
            end
        end

        lit_s = enable && (cnt_q >= GUARD_C) && !blank_sel_s;

        one_hot_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            one_hot_s[i] = lit_s && (idx_q == IDX_W'(i));
        end

        seg_raw_s = hex_to_seg(nib_s);
        if (lit_s) begin
            seg_d = SEG_ACTIVE_LOW ? ~seg_raw_s : seg_raw_s;
            dp_d  = SEG_ACTIVE_LOW ? ~dp_sel_s : dp_sel_s;
        end else begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end

        an_d         = AN_ACTIVE_LOW ? ~one_hot_s : one_hot_s;
        frame_done_d = enable && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    end

    // State and registered pin outputs; reset leaves every pin inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            val_q        <= '0;
            dpin_q       <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            dpin_q       <= dpin_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 8-clock slots, 1-clock guard, active-low pins):
// frame-position reference model checked every cycle, plus literal pins and random traffic.
module tb_seg7_scan_driver;

    localparam int D    = 4;
    localparam int DIV  = 8;
    localparam int GRD  = 1;
    localparam int FRAME = D * DIV;
    localparam logic [6:0] SEG_TAB [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    bit clk_run = 1'b0;
    bit chk_en  = 1'b0;
    int checks  = 0;
    int errors  = 0;
    int k       = 0;

    seg7_scan_driver #(
        .DIGITS(D), .REFRESH_DIV(DIV), .GUARD(GRD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Reference model: position within the frame (0..FRAME-1) decides digit and guard.
    int          pos;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    function automatic bit m_lit(input int p, input logic [15:0] v, input logic blz);
        int d;
        d = p / DIV;
        return ((p % DIV) >= GRD) && !(blz && d >= 1 && (v >> (4 * d)) == 16'h0000);
    endfunction

    function automatic logic [3:0] m_an(input int p, input logic [15:0] v, input logic blz);
        logic [3:0] one;
        one = 4'b0001 << (p / DIV);
        return m_lit(p, v, blz) ? ~one : 4'hF;
    endfunction

    function automatic logic [6:0] m_seg(input int p, input logic [15:0] v, input logic blz);
        logic [15:0] sh;
        sh = v >> (4 * (p / DIV));
        return m_lit(p, v, blz) ? ~SEG_TAB[sh[3:0]] : 7'h7F;
    endfunction

    function automatic logic m_dpo(input int p, input logic [15:0] v, input logic [3:0] dps,
                                   input logic blz);
        return m_lit(p, v, blz) ? ~dps[p / DIV] : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos   <= 0;
            m_val <= 16'h0000;
            m_dp  <= 4'h0;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
            e_an  <= 4'hF;
            e_fd  <= 1'b0;
        end else begin
            if (enable) begin
                e_an  <= m_an(pos, m_val, blank_lz);
                e_seg <= m_seg(pos, m_val, blank_lz);
                e_dp  <= m_dpo(pos, m_val, m_dp, blank_lz);
                e_fd  <= (pos == FRAME - 1);
                pos   <= (pos + 1) % FRAME;
            end else begin
                e_an  <= 4'hF;
                e_seg <= 7'h7F;
                e_dp  <= 1'b1;
                e_fd  <= 1'b0;
                pos   <= 0;
            end
            if (load) begin
                m_val <= value;
                m_dp  <= dp_in;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
        end
    end

    // Hand-computed expectation checked against both the DUT and the model.
    task automatic pin(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        chk({tag, "_an"}, 32'(an), 32'(a));
        chk({tag, "_seg"}, 32'(seg), 32'(s));
        chk({tag, "_dp"}, 32'(dp), 32'(d));
        chk({tag, "_model_an"}, 32'(e_an), 32'(a));
        chk({tag, "_model_seg"}, 32'(e_seg), 32'(s));
    endtask

    task automatic restart(input logic [15:0] v, input logic [3:0] d, input logic blz);
        enable   = 1'b0;
        load     = 1'b1;
        value    = v;
        dp_in    = d;
        blank_lz = blz;
        @(negedge clk);
        load   = 1'b0;
        enable = 1'b1;
        k      = 0;
    endtask

    task automatic step_to(input int target);
        repeat (target - k) @(negedge clk);
        k = target;
    endtask

    int nfd;
    int prev_fd;
    int first_fd;

    initial begin
        // Asynchronous reset with the clock stopped.
        #1 rst = 1'b1;
        #2;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'h0);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Plain scan of 12AF with digit 2 decimal point.
        restart(16'h12AF, 4'b0100, 1'b0);
        step_to(1);  pin("t2_guard0", 4'hF, 7'h7F, 1'b1);
        step_to(2);  pin("t2_d0", 4'hE, 7'b0111000, 1'b1);
        step_to(9);  pin("t2_guard1", 4'hF, 7'h7F, 1'b1);
        step_to(10); pin("t2_d1", 4'hD, 7'b0001000, 1'b1);
        step_to(18); pin("t2_d2", 4'hB, 7'b0010010, 1'b0);
        step_to(26); pin("t2_d3", 4'h7, 7'b1001111, 1'b1);
        step_to(32); chk("t2_fd_last", 32'(frame_done), 32'h1);
        step_to(33); pin("t2_wrap_guard", 4'hF, 7'h7F, 1'b1);
        step_to(34); pin("t2_repeat_d0", 4'hE, 7'b0111000, 1'b1);

        // Leading-zero blanking.
        restart(16'h0070, 4'b0000, 1'b1);
        step_to(2);  pin("t3_d0", 4'hE, 7'b0000001, 1'b1);
        step_to(10); pin("t3_d1", 4'hD, 7'b0001111, 1'b1);
        step_to(18); pin("t3_d2_blank", 4'hF, 7'h7F, 1'b1);
        step_to(26); pin("t3_d3_blank", 4'hF, 7'h7F, 1'b1);
        restart(16'h0000, 4'b0000, 1'b1);
        step_to(2);  pin("t3z_d0", 4'hE, 7'b0000001, 1'b1);
        step_to(10); pin("t3z_d1_blank", 4'hF, 7'h7F, 1'b1);
        step_to(26); pin("t3z_d3_blank", 4'hF, 7'h7F, 1'b1);

        // Free run: frame_done cadence.
        restart(16'h3C5E, 4'b1001, 1'b0);
        nfd = 0; prev_fd = -1; first_fd = -1;
        for (int c = 1; c <= 100; c++) begin
            step_to(c);
            if (frame_done) begin
                nfd++;
                if (prev_fd >= 0) chk("fd_period", 32'(c - prev_fd), 32'(FRAME));
                else first_fd = c;
                prev_fd = c;
            end
        end
        chk("fd_count", 32'(nfd), 32'd3);
        chk("fd_first", 32'(first_fd), 32'(FRAME));

        // Load mid-slot of digit 2.
        restart(16'h12AF, 4'b0100, 1'b0);
        step_to(20);
        load = 1'b1; value = 16'hBBBB;
        step_to(21); load = 1'b0;
        pin("t5_old", 4'hB, 7'b0010010, 1'b0);
        step_to(22); pin("t5_new", 4'hB, 7'b1100000, 1'b0);

        // Asynchronous reset mid-slot, dark while disabled, clean restart.
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_seg", 32'(seg), 32'h7F);
        chk("t6_rst_an", 32'(an), 32'hF);
        chk("t6_rst_dp", 32'(dp), 32'h1);
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
        repeat (10) @(negedge clk);
        pin("t6_dark", 4'hF, 7'h7F, 1'b1);
        enable = 1'b1; k = 0;
        step_to(1); pin("t6_guard", 4'hF, 7'h7F, 1'b1);
        step_to(2); pin("t6_d0", 4'hE, 7'b0000001, 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 19) != 0);
            load   = ($urandom_range(0, 9) == 0);
            value  = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_in  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
